// File: rtl/hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl
//
// Owns the architectural HI/LO registers and sequences signed (DIV) and
// unsigned (DIVU) divides through an external unsigned sequential divider.
// Signed operands are reduced to magnitudes before the divider sees them, and
// the result signs are restored in the FIX state. A zero divisor never
// reaches the divider: HI takes the dividend and LO takes all-ones at once.
//
// Handshake with the divider:
//   div_start is a one-cycle pulse, issued only from ARM. div_dividend and
//   div_divisor are held from that pulse until the result is taken.
//   div_done is a level that the divider drops after a start and raises
//   when its result is valid. It may still show the previous operation's
//   high in the first WAIT cycle, so that cycle ignores it.
//   stall is asked of the CPU whenever it presents a HI/LO-related request
//   while a divide is in flight; such requests are dropped and re-presented.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   op_div, op_divu             divide requests (op_div wins if both high)
//   rs_val, rt_val              dividend / divisor
//   op_mthi, op_mtlo, wr_data   MTHI / MTLO writes
//   rd_hilo                     MFHI / MFLO reading HI/LO this cycle
//   stall                       hold the current instruction (combinational)
//   hi, lo                      remainder / quotient registers
//   div_start, div_dividend,
//   div_divisor                 divider command
//   div_done, div_quotient,
//   div_remainder               divider response
//   dbgState                    FSM state (0 IDLE, 1 ARM, 2 WAIT, 3 FIX)
// ---------------------------------------------------------------------------
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] wr_data,
  input  logic        rd_hilo,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    FIX  = 2'd3
  } stateType;

  stateType state;
  logic     negQ;
  logic     negR;
  logic     waitFirst;

  logic        divReq;
  logic        rsNeg;
  logic        rtNeg;
  logic [31:0] rsMag;
  logic [31:0] rtMag;

  // Sign bits only matter for the signed op; DIVU treats operands as raw.
  assign divReq = op_div | op_divu;
  assign rsNeg  = op_div & rs_val[31];
  assign rtNeg  = op_div & rt_val[31];
  // Two's-complement negation of 0x80000000 is 0x80000000, which is the
  // correct unsigned magnitude, so no special case is needed.
  assign rsMag  = rsNeg ? (~rs_val + 32'd1) : rs_val;
  assign rtMag  = rtNeg ? (~rt_val + 32'd1) : rt_val;

  assign stall    = (state != IDLE) & (op_div | op_divu | op_mthi | op_mtlo | rd_hilo);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hi           <= 32'd0;
      lo           <= 32'd0;
      div_start    <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      negQ         <= 1'b0;
      negR         <= 1'b0;
      waitFirst    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_start <= 1'b0;
          if (divReq) begin
            // A divide in the same cycle as MTHI/MTLO drops the MT writes.
            if (rt_val == 32'd0) begin
              hi <= rs_val;
              lo <= 32'hFFFF_FFFF;
            end else begin
              div_dividend <= rsMag;
              div_divisor  <= rtMag;
              negQ         <= rsNeg ^ rtNeg;
              negR         <= rsNeg;
              div_start    <= 1'b1;
              state        <= ARM;
            end
          end else begin
            if (op_mthi) hi <= wr_data;
            if (op_mtlo) lo <= wr_data;
          end
        end
        ARM: begin
          div_start <= 1'b0;
          waitFirst <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          // The first WAIT cycle may still see done from the previous divide.
          waitFirst <= 1'b0;
          if (!waitFirst && div_done) state <= FIX;
        end
        FIX: begin
          lo    <= negQ ? (~div_quotient + 32'd1) : div_quotient;
          hi    <= negR ? (~div_remainder + 32'd1) : div_remainder;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_ctrl
//
// Directed bench for hilo_div_ctrl. A behavioural unsigned divider sits on
// the divider port: it registers div_start, drops div_done one cycle later
// (so a stale done is visible in the first WAIT cycle) and raises it with
// the result LAT cycles after that. Inputs are driven 1 ns after the rising
// edge; outputs are checked there too, and stall is sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_hilo_div_ctrl;

  localparam int         LAT    = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        op_div = 1'b0, op_divu = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
  logic        rd_hilo = 1'b0;
  logic [31:0] rs_val = '0, rt_val = '0, wr_data = '0;
  logic        stall, div_start, div_done;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_quotient, div_remainder;
  logic [1:0]  dbgState;

  hilo_div_ctrl dut (
    .clk(clk), .reset(reset),
    .op_div(op_div), .op_divu(op_divu),
    .rs_val(rs_val), .rt_val(rt_val),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo), .wr_data(wr_data),
    .rd_hilo(rd_hilo), .stall(stall),
    .hi(hi), .lo(lo),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .dbgState(dbgState)
  );

  // ---------------- divider model ----------------
  logic        startPend = 1'b0;
  logic [31:0] opA = '0, opB = '0;
  int          cnt = 0;
  initial begin
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
  end
  always @(posedge clk) begin
    startPend <= div_start;
    if (div_start) begin
      opA <= div_dividend;
      opB <= div_divisor;
    end
    if (startPend) begin
      div_done <= 1'b0;
      cnt      <= LAT;
    end else if (!div_done && cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        div_done      <= 1'b1;
        div_quotient  <= (opB == 0) ? 32'hFFFF_FFFF : opA / opB;
        div_remainder <= (opB == 0) ? opA : opA % opB;
      end
    end
  end

  // ---------------- monitors ----------------
  int unsigned startCnt = 0;
  bit          stallSeen = 1'b0;
  always @(posedge clk) if (div_start === 1'b1) startCnt++;
  always @(negedge clk) if (stall === 1'b1) stallSeen = 1'b1;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] expLo;
    logic [31:0] expHi;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (dbgState !== S_IDLE && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Presents one divide for a single cycle, then waits for it to finish.
  task automatic runVec(input vec_t v, input bit withMt);
    int unsigned startBefore;
    int          cycles;
    tick();
    op_div  = v.sgn;
    op_divu = !v.sgn;
    rs_val  = v.rs;
    rt_val  = v.rt;
    op_mthi = withMt;
    op_mtlo = withMt;
    wr_data = 32'hDEAD_BEEF;
    startBefore = startCnt;
    stallSeen   = 1'b0;
    tick();
    op_div = 0; op_divu = 0; op_mthi = 0; op_mtlo = 0;
    exp_q.push_back(v.expLo);
    exp_q.push_back(v.expHi);
    if (v.rt == 32'd0) begin
      chk({v.name, "_state"}, {30'd0, dbgState}, {30'd0, S_IDLE});
      tick();
      chk({v.name, "_nostart"}, startCnt - startBefore, 0);
      chk({v.name, "_nostall"}, {31'd0, stallSeen}, 0);
    end else begin
      waitIdle(cycles);
      chk({v.name, "_latency"}, cycles, LAT + 4);
      chk({v.name, "_starts"}, startCnt - startBefore, 1);
    end
    chk({v.name, "_lo"}, lo, exp_q.pop_front());
    chk({v.name, "_hi"}, hi, exp_q.pop_front());
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cycles;
    bit          allStall;
    bit          loHeld;
    logic [31:0] loBefore;
    int unsigned startBefore;

    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{"div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[5] = '{"divu_big",     1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
    vecs[6] = '{"divu_min_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[7] = '{"divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[8] = '{"div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk("rst_start", {31'd0, div_start}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);

    // Table: every divide after the first starts with done still high.
    for (int i = 0; i < 9; i++) runVec(vecs[i], 1'b0);

    // MTHI and MTLO together, then MTLO alone
    tick();
    op_mthi = 1; op_mtlo = 1; wr_data = 32'hAAAA_5555;
    tick();
    op_mthi = 0; op_mtlo = 0;
    chk("mt_both_hi", hi, 32'hAAAA_5555);
    chk("mt_both_lo", lo, 32'hAAAA_5555);
    op_mtlo = 1; wr_data = 32'h0000_0BAD;
    tick();
    op_mtlo = 0;
    chk("mtlo_hi", hi, 32'hAAAA_5555);
    chk("mtlo_lo", lo, 32'h0000_0BAD);

    // Divide and MT writes in the same cycle: divide wins
    runVec('{"divu_vs_mt", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2}, 1'b1);

    // DIVU 100/7 with MFHI/MFLO held: stall in every busy cycle
    tick();
    op_divu = 1; rs_val = 32'd100; rt_val = 32'd7; rd_hilo = 1;
    startBefore = startCnt;
    tick();
    op_divu = 0;
    allStall = 1'b1;
    cycles = 0;
    while (dbgState !== S_IDLE && cycles < 100) begin
      if (stall !== 1'b1) allStall = 1'b0;
      tick();
      cycles++;
    end
    chk("rd_stall_busy", {31'd0, allStall}, 1);
    chk("rd_stall_idle", {31'd0, stall}, 0);
    chk("rd_starts", startCnt - startBefore, 1);
    chk("rd_lo", lo, 32'd14);
    chk("rd_hi", hi, 32'd2);
    rd_hilo = 0;

    // MTLO held during a busy divide: stall, lo frozen, write lands in IDLE
    tick();
    op_divu = 1; rs_val = 32'd50; rt_val = 32'd5;
    tick();
    op_divu = 0;
    op_mtlo = 1; wr_data = 32'h0000_1234;
    loBefore = lo;
    allStall = 1'b1;
    loHeld   = 1'b1;
    cycles = 0;
    while (dbgState !== S_IDLE && cycles < 100) begin
      #4;
      if (stall !== 1'b1) allStall = 1'b0;
      if (lo !== loBefore) loHeld = 1'b0;
      tick();
      cycles++;
    end
    chk("mtbusy_stall", {31'd0, allStall}, 1);
    chk("mtbusy_loheld", {31'd0, loHeld}, 1);
    chk("mtbusy_lo_div", lo, 32'd10);
    chk("mtbusy_hi_div", hi, 32'd0);
    tick();
    op_mtlo = 0;
    chk("mtbusy_lo_mt", lo, 32'h0000_1234);

    // Reset while in WAIT; the late done must be ignored
    tick();
    op_divu = 1; rs_val = 32'd1000; rt_val = 32'd3;
    tick();
    op_divu = 0;
    tick();
    chk("rw_in_wait", {30'd0, dbgState}, {30'd0, S_WAIT});
    reset = 1;
    tick();
    reset = 0;
    chk("rw_hi", hi, 0);
    chk("rw_lo", lo, 0);
    chk("rw_state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk("rw_dividend", div_dividend, 0);
    startBefore = startCnt;
    for (int i = 0; i < LAT + 6; i++) tick();
    chk("rw_done_seen", {31'd0, div_done}, 1);
    chk("rw_late_state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk("rw_late_lo", lo, 0);
    chk("rw_late_hi", hi, 0);
    chk("rw_late_nostart", startCnt - startBefore, 0);
    runVec('{"post_reset_divu", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 op_div  input  1  request signed DIV of rs_val by rt_val.
REQ-005 op_divu  input  1  request unsigned DIVU of rs_val by rt_val.
REQ-006 rs_val  input  32  dividend operand.
REQ-007 rt_val  input  32  divisor operand.
REQ-008 op_mthi / op_mtlo  input  1 each  write wr_data to HI / LO.
REQ-009 wr_data  input  32  data for MTHI/MTLO.
REQ-010 rd_hilo  input  1  MFHI/MFLO is consuming hi/lo this cycle.
REQ-011 stall  output  1  CPU must hold its current instruction.
REQ-012 hi, lo  output  32 each  architectural HI (remainder) and LO (quotient) registers.
REQ-013 div_start  output  1  one-cycle start pulse to the sequential divider.
REQ-014 div_dividend, div_divisor  output  32 each  unsigned magnitudes driven to the divider, held stable from div_start until the divider completes.
REQ-015 div_done  input  1  divider done level: cleared by start, high once the result is valid, and held high until the next start.
REQ-016 div_quotient, div_remainder  input  32 each  unsigned divider results.

Function
REQ-017 SHALL implement the FSM states IDLE, ARM, WAIT and FIX; busy = (state != IDLE).
REQ-018 IDLE, with op_div or op_divu high and rt_val != 0:
- register the operand magnitudes: |x| for a signed op, raw value for an unsigned op;
- register neg_q = sign(rs) XOR sign(rt) and neg_r = sign(rs), both forced to 0 for DIVU;
- go to ARM.
REQ-019 ARM SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL ignore div_done in its first cycle, because a stale high from the previous operation may still be present.
REQ-021 From its second cycle on, WAIT SHALL go to FIX on div_done = 1.
REQ-022 FIX SHALL load the results and go to IDLE:
- lo = neg_q ? -div_quotient : div_quotient (32-bit two's-complement wrap);
- hi = neg_r ? -div_remainder : div_remainder.
REQ-023 Magnitude of 0x80000000 SHALL be 0x80000000 treated as unsigned. DIV 0x80000000 / 0xFFFFFFFF therefore yields lo = 0x80000000, hi = 0.
REQ-024 Divide by zero (rt_val = 0), in IDLE, SHALL bypass the divider:
- hi = rs_val, lo = 0xFFFFFFFF on the next edge;
- state stays IDLE and no div_start is issued.
REQ-025 In IDLE, op_mthi / op_mtlo SHALL write wr_data to hi / lo on the next edge, and both may be written in the same cycle.
REQ-026 If a divide op and op_mthi/op_mtlo are high in the same IDLE cycle, the divide SHALL win and the MT writes SHALL be dropped.
REQ-027 stall = busy AND (op_div OR op_divu OR op_mthi OR op_mtlo OR rd_hilo), combinational.
REQ-028 Requests seen while busy SHALL NOT change state, hi or lo; the CPU re-presents them, held by stall.
REQ-029 hi/lo SHALL change only in FIX, on a divide-by-zero, or on an MT write; otherwise they hold.
REQ-030 Latency SHALL be: request edge -> ARM (1) -> WAIT (>= 2) -> FIX (1) -> hi/lo valid on the edge leaving FIX, i.e. divider latency + 3 cycles.
REQ-031 A non-divide cycle SHALL NOT assert div_start.

Reset
REQ-032 Reset SHALL take effect on the next rising clk edge, with priority over all other inputs.
REQ-033 Reset values SHALL be:
- state = IDLE;
- hi = 0, lo = 0;
- div_start = 0, stall = 0;
- div_dividend = 0, div_divisor = 0;
- neg_q = neg_r = 0.
REQ-034 Reset mid-operation SHALL abandon the divide, and any later div_done SHALL be ignored while in IDLE.
REQ-035 The next divide after reset SHALL restart the divider through a fresh div_start.

Verification
REQ-036 DIVU 100 / 7 -> one div_start pulse, stall held while rd_hilo is high -> lo = 14, hi = 2.
REQ-037 DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-038 DIV 7 / 0xFFFFFFFE (-2) -> lo = 0xFFFFFFFD, hi = 1.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-040 DIVU 5 / 0 -> no div_start, stall never asserted -> next cycle hi = 5, lo = 0xFFFFFFFF.
REQ-041 Back-to-back DIVU with div_done still high from the previous op -> the result is not taken before the new done.
REQ-042 MTLO 0x1234 issued during a busy divide -> stall asserted and lo unchanged until IDLE.
REQ-043 Reset in WAIT -> hi = lo = 0, IDLE, late div_done ignored.
